pong_engine: RTL

Parametrised successor to the fixed 640x480 pong game logic. It takes the per-frame update out of the video timing. A single frame_tick strobe drives an explicit game FSM with four states: idle, serve delay, play and game over. Geometry, win score and speed cap are generics. Its outputs are the object positions and scores consumed by playfield.

---
 rtl/pong_engine.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pong_engine.sv
// pong_engine: per-frame game logic for a two-player pong playfield.
// One accepted frame_tick runs the game FSM, then STICK_STEPS stick steps,
// then (in PLAY) one ball step per level, one pixel per clock cycle.
//
// state | meaning
// IDLE  | after reset, waiting for start; ball hidden, scores blank
// SERVE | ball centred and held for SERVE_FRAMES ticks
// PLAY  | ball stepping; exits score, walls and sticks bounce
// OVER  | a player reached WIN_SCORE; ball hidden, waiting for start
module pong_engine #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int STICK_SIZE   = 64,
    parameter int STICK_W      = 8,
    parameter int BALL_SIZE    = 8,
    parameter int P1_X         = 16,
    parameter int P2_X         = 616,
    parameter int WIN_SCORE    = 9,
    parameter int MAX_LEVEL    = 15,
    parameter int STICK_STEPS  = 4,
    parameter int SERVE_FRAMES = 60,
    localparam int XW = $clog2(H_RES),
    localparam int YW = $clog2(V_RES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic          p1_btup,
    input  logic          p1_btdown,
    input  logic          p2_btup,
    input  logic          p2_btdown,
    input  logic          p1_auto,
    input  logic          p2_auto,
    input  logic          start,
    output logic [YW-1:0] stickp1,
    output logic [YW-1:0] stickp2,
    output logic [XW-1:0] ballx,
    output logic [YW-1:0] bally,
    output logic          ball_visible,
    output logic [3:0]    scorep1,
    output logic [3:0]    scorep2,
    output logic [3:0]    level,
    output logic [1:0]    state,
    output logic          game_over
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int PW = $clog2(STICK_STEPS + MAX_LEVEL + 2);
    localparam int CW = $clog2(SERVE_FRAMES + 1);
    localparam int YE = YW + 1;

    localparam logic [YW-1:0] STICK_Y0  = YW'((V_RES - STICK_SIZE) / 2);
    localparam logic [YW-1:0] STICK_MAX = YW'(V_RES - STICK_SIZE);
    localparam logic [XW-1:0] BALL_X0   = XW'((H_RES - BALL_SIZE) / 2);
    localparam logic [YW-1:0] BALL_Y0   = YW'((V_RES - BALL_SIZE) / 2);
    localparam logic [XW-1:0] BALL_XMAX = XW'(H_RES - BALL_SIZE);
    localparam logic [YW-1:0] BALL_YMAX = YW'(V_RES - BALL_SIZE);
    localparam logic [XW-1:0] P1_HIT_X  = XW'(P1_X + STICK_W);
    localparam logic [XW-1:0] P2_HIT_X  = XW'(P2_X - BALL_SIZE);
    localparam logic [XW-1:0] H_HALF    = XW'(H_RES / 2);
    localparam logic [YE-1:0] SS_E      = YE'(STICK_SIZE);
    localparam logic [YE-1:0] T1_E      = YE'(STICK_SIZE / 3);
    localparam logic [YE-1:0] T2_E      = YE'(2 * STICK_SIZE / 3);
    localparam logic [YE-1:0] B_E       = YE'(BALL_SIZE);
    localparam logic [YE-1:0] BH_E      = YE'(BALL_SIZE / 2);
    localparam logic [PW-1:0] PH_STICK  = PW'(STICK_STEPS);
    localparam logic [CW-1:0] SERVE_C   = CW'(SERVE_FRAMES);
    localparam logic [3:0]    WIN4      = 4'(WIN_SCORE);
    localparam logic [3:0]    MAX4      = 4'(MAX_LEVEL);
    localparam logic [1:0]    INC_POS   = 2'b01;
    localparam logic [1:0]    INC_NEG   = 2'b11;

    state_t        st_q, st_d;
    logic [YW-1:0] stick1_q, stick1_d, stick2_q, stick2_d;
    logic [XW-1:0] bx_q, bx_d;
    logic [YW-1:0] by_q, by_d;
    logic [1:0]    incx_q, incx_d, incy_q, incy_d;
    logic          vis_q, vis_d;
    logic [3:0]    sc1_q, sc1_d, sc2_q, sc2_d;
    logic [3:0]    lvl_q, lvl_d, lvl_lat_q, lvl_lat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] phase_q, phase_d;

    logic [YE-1:0] by_e, s1_e, s2_e, ctr_e;
    logic          p1_up, p1_dn, p2_up, p2_dn;
    logic          wall, hit1, hit2, top1, bot1, top2, bot2;
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    logic [3:0]    lvl_up, new_sc;
    logic          enter_serve, pt1, pt2, seq_last;

    // Up wins over down; position saturates at both ends of the playfield.
    function automatic logic [YW-1:0] stick_step(input logic [YW-1:0] s,
                                                 input logic up,
                                                 input logic dn);
        if (up)
            return (s == '0) ? s : s - 1'b1;
        else if (dn)
            return (s >= STICK_MAX) ? s : s + 1'b1;
        else
            return s;
    endfunction

    // Stick controls, hit geometry and ball increments derived from current state.
    always_comb begin
        by_e  = {1'b0, by_q};
        s1_e  = {1'b0, stick1_q};
        s2_e  = {1'b0, stick2_q};
        ctr_e = by_e + BH_E;

        p1_up = p1_auto ? ((bx_q < H_HALF) && (by_e < s1_e + T1_E)) : p1_btup;
        p1_dn = p1_auto ? ((bx_q < H_HALF) && (by_e >= s1_e + T2_E)) : p1_btdown;
        p2_up = p2_auto ? ((bx_q >= H_HALF) && (by_e < s2_e + T1_E)) : p2_btup;
        p2_dn = p2_auto ? ((bx_q >= H_HALF) && (by_e >= s2_e + T2_E)) : p2_btdown;

        wall = ((by_q == '0) && (incy_q == INC_NEG)) ||
               ((by_q == BALL_YMAX) && (incy_q == INC_POS));
        hit1 = (bx_q == P1_HIT_X) && (incx_q == INC_NEG) &&
               (by_e + B_E > s1_e) && (by_e < s1_e + SS_E);
        hit2 = (bx_q == P2_HIT_X) && (incx_q == INC_POS) &&
               (by_e + B_E > s2_e) && (by_e < s2_e + SS_E);
        top1 = ctr_e < s1_e + T1_E;
        bot1 = ctr_e >= s1_e + T2_E;
        top2 = ctr_e < s2_e + T1_E;
        bot2 = ctr_e >= s2_e + T2_E;

        dx     = {{(XW-2){incx_q[1]}}, incx_q};
        dy     = {{(YW-2){incy_q[1]}}, incy_q};
        lvl_up = (lvl_q < MAX4) ? lvl_q + 4'd1 : lvl_q;
    end

    // Frame sequencer, game FSM and ball/stick stepping next-state logic.
    always_comb begin
        st_d        = st_q;
        stick1_d    = stick1_q;
        stick2_d    = stick2_q;
        bx_d        = bx_q;
        by_d        = by_q;
        incx_d      = incx_q;
        incy_d      = incy_q;
        vis_d       = vis_q;
        sc1_d       = sc1_q;
        sc2_d       = sc2_q;
        lvl_d       = lvl_q;
        lvl_lat_d   = lvl_lat_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        phase_d     = phase_q;
        enter_serve = 1'b0;
        pt1         = 1'b0;
        pt2         = 1'b0;
        seq_last    = 1'b0;
        new_sc      = 4'd0;

        if (frame_tick && !busy_q) begin
            busy_d    = 1'b1;
            phase_d   = PW'(1);
            lvl_lat_d = lvl_q;
            unique case (st_q)
                ST_IDLE, ST_OVER: enter_serve = start;
                ST_SERVE: begin
                    if (cnt_q == '0)
                        st_d = ST_PLAY;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
                default: ;
            endcase
            if (enter_serve) begin
                st_d   = ST_SERVE;
                sc1_d  = 4'd0;
                sc2_d  = 4'd0;
                lvl_d  = 4'd1;
                bx_d   = BALL_X0;
                by_d   = BALL_Y0;
                incx_d = INC_POS;
                incy_d = INC_POS;
                vis_d  = 1'b1;
                cnt_d  = SERVE_C;
            end
        end else if (busy_q) begin
            phase_d = phase_q + 1'b1;
            if (phase_q <= PH_STICK) begin
                stick1_d = stick_step(stick1_q, p1_up, p1_dn);
                stick2_d = stick_step(stick2_q, p2_up, p2_dn);
            end else if (st_q == ST_PLAY) begin
                if (bx_q == '0) begin
                    pt2 = 1'b1;
                end else if (bx_q == BALL_XMAX) begin
                    pt1 = 1'b1;
                end else if (wall) begin
                    incy_d = -incy_q;
                end else if (hit1) begin
                    incx_d = INC_POS;
                    lvl_d  = lvl_up;
                    if (top1)
                        incy_d = INC_NEG;
                    else if (bot1)
                        incy_d = INC_POS;
                end else if (hit2) begin
                    incx_d = INC_NEG;
                    lvl_d  = lvl_up;
                    if (top2)
                        incy_d = INC_NEG;
                    else if (bot2)
                        incy_d = INC_POS;
                end else begin
                    bx_d = bx_q + dx;
                    by_d = by_q + dy;
                end
            end

            // A point aborts whatever ball steps remain in this frame.
            if (pt1 || pt2) begin
                new_sc = (pt1 ? sc1_q : sc2_q) + 4'd1;
                if (pt1)
                    sc1_d = new_sc;
                else
                    sc2_d = new_sc;
                if (new_sc == WIN4) begin
                    st_d  = ST_OVER;
                    vis_d = 1'b0;
                end else begin
                    st_d   = ST_SERVE;
                    bx_d   = BALL_X0;
                    by_d   = BALL_Y0;
                    lvl_d  = 4'd1;
                    cnt_d  = SERVE_C;
                    incy_d = INC_POS;
                    incx_d = pt2 ? INC_NEG : INC_POS;
                end
            end

            seq_last = pt1 || pt2 ||
                       (phase_q >= PH_STICK + ((st_q == ST_PLAY) ? PW'(lvl_lat_q) : '0));
            if (seq_last)
                busy_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= ST_IDLE;
            stick1_q  <= STICK_Y0;
            stick2_q  <= STICK_Y0;
            bx_q      <= BALL_X0;
            by_q      <= BALL_Y0;
            incx_q    <= INC_POS;
            incy_q    <= INC_POS;
            vis_q     <= 1'b0;
            sc1_q     <= 4'hF;
            sc2_q     <= 4'hF;
            lvl_q     <= 4'd1;
            lvl_lat_q <= 4'd1;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            phase_q   <= '0;
        end else begin
            st_q      <= st_d;
            stick1_q  <= stick1_d;
            stick2_q  <= stick2_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            incx_q    <= incx_d;
            incy_q    <= incy_d;
            vis_q     <= vis_d;
            sc1_q     <= sc1_d;
            sc2_q     <= sc2_d;
            lvl_q     <= lvl_d;
            lvl_lat_q <= lvl_lat_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            phase_q   <= phase_d;
        end
    end

    assign stickp1      = stick1_q;
    assign stickp2      = stick2_q;
    assign ballx        = bx_q;
    assign bally        = by_q;
    assign ball_visible = vis_q;
    assign scorep1      = sc1_q;
    assign scorep2      = sc2_q;
    assign level        = lvl_q;
    assign state        = st_q;
    assign game_over    = (st_q == ST_OVER);

endmodule
